// File: rtl/pattern_store_if.sv
// pattern_store_if: host port A, engine control and row stream.
// Optional PATTERN_STORE_MIRROR_EN adds the mirror request bit.
interface pattern_store_if #(
  parameter int ROW_W    = 128,
  parameter int ADDR_W   = 10,
  parameter int PAT_ROWS = 64
);
  localparam int IDX_W  = $clog2(PAT_ROWS);
  localparam int PSEL_W = ADDR_W - IDX_W;

  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [ROW_W-1:0]  dina;
  logic [ROW_W-1:0]  douta;
  logic              start;
  logic [PSEL_W-1:0] pat_sel;
`ifdef PATTERN_STORE_MIRROR_EN
  logic              mirror;
`endif
  logic              busy;
  logic              done;
  logic              out_valid;
  logic              out_ready;
  logic [ROW_W-1:0]  out_row;
  logic [IDX_W-1:0]  out_idx;

  modport master (
`ifdef PATTERN_STORE_MIRROR_EN
    output mirror,
`endif
    output wea, addra, dina,
    output start, pat_sel, out_ready,
    input  douta, busy, done,
    input  out_valid, out_row, out_idx
  );

  modport slave (
`ifdef PATTERN_STORE_MIRROR_EN
    input  mirror,
`endif
    input  wea, addra, dina,
    input  start, pat_sel, out_ready,
    output douta, busy, done,
    output out_valid, out_row, out_idx
  );
endinterface

// File: rtl/pattern_store.sv
// pattern_store: dual-port row store with a pattern streaming engine.
// Define PATTERN_STORE_MIRROR_EN to enable bit-reversed streaming.
module pattern_store #(
  parameter int ROW_W    = 128,
  parameter int ADDR_W   = 10,
  parameter int PAT_ROWS = 64
) (
  input  logic          clka,
  input  logic          rsta,
  pattern_store_if.slave bus
);
  localparam int IDX_W  = $clog2(PAT_ROWS);
  localparam int PSEL_W = ADDR_W - IDX_W;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE, FETCH, STREAM, FLUSH
  } state_t;

  state_t state, state_nx;

  logic [ROW_W-1:0]  mem [DEPTH];
  logic [ROW_W-1:0]  douta_q;
  logic [ROW_W-1:0]  rd_q;
  logic [ROW_W-1:0]  row_o;
  logic [PSEL_W-1:0] psel_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_nx;
  logic [ADDR_W-1:0] addrb;
  logic              hs;
  logic              last;
  logic              rd_en;
  logic              take;
  logic              mir_q;

  assign take  = (state == IDLE) && bus.start;
  assign hs    = (state == STREAM) && bus.out_ready;
  assign last  = idx_q == IDX_W'(PAT_ROWS - 1);
  assign rd_en = (state == FETCH) || (hs && !last);

  // Row address stays inside the captured pattern.
  assign idx_nx = (state == FETCH) ? '0
                                   : idx_q + 1'b1;
  assign addrb  = {psel_q, idx_nx};

  // Host write port; writes are blocked while in reset.
  always_ff @(posedge clka) begin
    if (bus.wea && !rsta)
      mem[bus.addra] <= bus.dina;
  end

  // Host read port, read-first.
  always_ff @(posedge clka) begin
    if (rsta)
      douta_q <= '0;
    else
      douta_q <= mem[bus.addra];
  end

  // Engine read port; holds the row while stalled.
  always_ff @(posedge clka) begin
    if (rsta)
      rd_q <= '0;
    else if (rd_en)
      rd_q <= mem[addrb];
  end

  // Engine state register.
  always_ff @(posedge clka) begin
    if (rsta)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Pattern select, mirror and row index tracking.
  always_ff @(posedge clka) begin
    if (rsta) begin
      psel_q <= '0;
      idx_q  <= '0;
      mir_q  <= 1'b0;
    end else if (take) begin
      psel_q <= bus.pat_sel;
      idx_q  <= '0;
`ifdef PATTERN_STORE_MIRROR_EN
      mir_q  <= bus.mirror;
`else
      mir_q  <= 1'b0;
`endif
    end else if (hs) begin
      idx_q  <= idx_q + 1'b1;
    end
  end

  // Engine next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (bus.start) state_nx = FETCH;
      FETCH:  state_nx = STREAM;
      STREAM: if (hs && last) state_nx = FLUSH;
      FLUSH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Optional bit reversal of the streamed row.
  always_comb begin
    row_o = rd_q;
    if (mir_q)
      for (int i = 0; i < ROW_W; i++)
        row_o[i] = rd_q[ROW_W-1-i];
  end

  assign bus.douta     = douta_q;
  assign bus.busy      = state != IDLE;
  assign bus.done      = state == FLUSH;
  assign bus.out_valid = state == STREAM;
  assign bus.out_row   = row_o;
  assign bus.out_idx   = idx_q;
endmodule

// File: tb/tb_pattern_store.sv
// tb_pattern_store: random scoreboard bench for pattern_store.
// Reference model is a flat row array snapshotted at each start.
module tb_pattern_store;
  localparam int RW = 128;
  localparam int AW = 10;
  localparam int PR = 64;
  localparam int IW = 6;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [RW-1:0] row;
    logic [IW-1:0] idx;
  } exp_t;

  logic clka;
  logic rsta;
  int   checks;
  int   failures;
  int   rdy_mode;
  int   hs_cnt;

  logic [RW-1:0] model [DEPTH];
  exp_t q[$];

  pattern_store_if #(
    .ROW_W(RW), .ADDR_W(AW), .PAT_ROWS(PR)
  ) b ();

  pattern_store #(
    .ROW_W(RW), .ADDR_W(AW), .PAT_ROWS(PR)
  ) dut (
    .clka(clka),
    .rsta(rsta),
    .bus(b)
  );

  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  task automatic chk(input string nm,
                     input logic [RW-1:0] act,
                     input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] rev(input logic [RW-1:0] v);
    logic [RW-1:0] r;
    for (int i = 0; i < RW; i++) r[RW-1-i] = v[i];
    return r;
  endfunction

  task automatic tick;
    @(posedge clka);
    #1;
  endtask

  // Downstream ready pattern: always, alternating, or random.
  initial begin
    b.out_ready = 1'b1;
    forever begin
      @(posedge clka);
      #1;
      case (rdy_mode)
        0:       b.out_ready = 1'b1;
        1:       b.out_ready = ~b.out_ready;
        default: b.out_ready = 1'($urandom % 2);
      endcase
    end
  end

  // Monitor: pops expected rows on handshakes, checks stalls and done.
  logic          done_due;
  logic          stall_p;
  logic [RW-1:0] row_p;
  logic [IW-1:0] idx_p;
  exp_t          me;
  initial begin
    done_due = 1'b0;
    stall_p  = 1'b0;
    row_p    = '0;
    idx_p    = '0;
    hs_cnt   = 0;
    forever begin
      @(negedge clka);
      if (rsta) begin
        done_due = 1'b0;
        stall_p  = 1'b0;
      end else begin
        if (done_due || b.done)
          chk("done_pulse", {b.done, b.busy},
              {done_due, done_due});
        done_due = 1'b0;
        if (stall_p && b.out_valid) begin
          chk("stall_row", b.out_row, row_p);
          chk("stall_idx", b.out_idx, idx_p);
        end
        if (b.out_valid && b.out_ready) begin
          hs_cnt++;
          if (q.size() == 0) begin
            chk("extra_row", 1, 0);
          end else begin
            me = q.pop_front();
            chk("row", b.out_row, me.row);
            chk("idx", b.out_idx, me.idx);
            if (me.idx == IW'(PR - 1)) done_due = 1'b1;
          end
        end
        stall_p = b.out_valid && !b.out_ready;
        row_p   = b.out_row;
        idx_p   = b.out_idx;
      end
    end
  end

  task automatic wr(input int a, input logic [RW-1:0] d);
    b.wea   = 1'b1;
    b.addra = AW'(a);
    b.dina  = d;
    tick;
    b.wea   = 1'b0;
    model[a] = d;
  endtask

  task automatic rd_chk(input int a);
    b.addra = AW'(a);
    tick;
    chk("douta", b.douta, model[a]);
  endtask

  task automatic start_pat(input int p, input logic m,
                           input logic hit);
    exp_t e;
    logic [RW-1:0] old;
    for (int i = 0; i < PR; i++) begin
      e.idx = IW'(i);
      e.row = m ? rev(model[p*PR+i]) : model[p*PR+i];
      q.push_back(e);
    end
    b.start   = 1'b1;
    b.pat_sel = 4'(p);
`ifdef PATTERN_STORE_MIRROR_EN
    b.mirror  = m;
`endif
    tick;
    b.start = 1'b0;
    old = model[p*PR];
    if (hit) begin
      b.wea   = 1'b1;
      b.addra = AW'(p*PR);
      b.dina  = '1;
    end
    chk("busy_c1", b.busy, 1);
    chk("valid_c1", b.out_valid, 0);
    tick;
    chk("valid_c2", b.out_valid, 1);
    if (hit) begin
      b.wea = 1'b0;
      model[p*PR] = '1;
      chk("douta_old", b.douta, old);
      tick;
      chk("douta_new", b.douta, model[p*PR]);
    end
  endtask

  task automatic wait_done(input int expn);
    int n;
    n = 0;
    while (!b.done && n < 5000) begin
      tick;
      n++;
    end
    if (!b.done) begin
      chk("done_timeout", 0, 1);
    end else if (expn >= 0) begin
      chk("done_time", n, expn);
    end
    tick;
    chk("busy_after", b.busy, 0);
    chk("q_empty", q.size(), 0);
  endtask

  initial begin
    int h0;
    int n;
    int p;
    int pats [4];
    logic [RW-1:0] d;
    checks   = 0;
    failures = 0;
    rdy_mode = 0;
    pats     = '{0, 1, 2, 15};
    rsta     = 1'b1;
    b.wea    = 1'b0;
    b.addra  = '0;
    b.dina   = '0;
    b.start  = 1'b0;
    b.pat_sel = '0;
`ifdef PATTERN_STORE_MIRROR_EN
    b.mirror = 1'b0;
`endif
    repeat (3) tick;
    chk("rst_busy", b.busy, 0);
    chk("rst_done", b.done, 0);
    chk("rst_valid", b.out_valid, 0);
    chk("rst_idx", b.out_idx, 0);
    chk("rst_row", b.out_row, 0);
    chk("rst_douta", b.douta, 0);
    rsta = 1'b0;

    d = {$urandom, $urandom, $urandom, $urandom};
    wr(5, d);
    rsta    = 1'b1;
    b.wea   = 1'b1;
    b.addra = AW'(5);
    b.dina  = ~d;
    tick;
    tick;
    chk("rst_douta2", b.douta, 0);
    b.wea = 1'b0;
    rsta  = 1'b0;
    rd_chk(5);

    for (int k = 0; k < 4; k++)
      for (int i = 0; i < PR; i++) begin
        n = pats[k] * PR + i;
        if (pats[k] == 1) d = {8{16'(n)}};
        else d = {$urandom, $urandom, $urandom, $urandom};
        wr(n, d);
      end
    rd_chk(64);
    rd_chk(127);
    rd_chk(1023);

    rdy_mode = 0;
    start_pat(1, 1'b0, 1'b0);
    wait_done(64);

    rdy_mode = 1;
    h0 = hs_cnt;
    start_pat(1, 1'b0, 1'b0);
    wait_done(-1);
    chk("hs_count", hs_cnt - h0, 64);

    rdy_mode = 2;
    start_pat(15, 1'b0, 1'b0);
    wait_done(-1);

    start_pat(1, 1'b0, 1'b1);
    wait_done(-1);
    rd_chk(64);

    rdy_mode = 0;
    h0 = hs_cnt;
    start_pat(2, 1'b0, 1'b0);
    n = 0;
    while (hs_cnt - h0 < 10 && n < 200) begin
      tick;
      n++;
    end
    rsta = 1'b1;
    tick;
    chk("abort_busy", b.busy, 0);
    chk("abort_valid", b.out_valid, 0);
    chk("abort_done", b.done, 0);
    chk("abort_idx", b.out_idx, 0);
    rsta = 1'b0;
    q.delete();
    repeat (3) tick;
    chk("abort_idle", b.busy, 0);
    rd_chk(2*PR + 3);
    start_pat(2, 1'b0, 1'b0);
    wait_done(64);

    for (int k = 0; k < 4; k++) begin
      rdy_mode = int'($urandom_range(0, 2));
      p = pats[$urandom_range(0, 3)];
      start_pat(p, 1'b0, 1'b0);
      b.start   = 1'b1;
      b.pat_sel = 4'(pats[(k + 1) % 4]);
      tick;
      b.start = 1'b0;
      wait_done(-1);
    end

`ifdef PATTERN_STORE_MIRROR_EN
    rdy_mode = 2;
    d = '0;
    d[0] = 1'b1;
    wr(0, d);
    start_pat(0, 1'b1, 1'b0);
    wait_done(-1);
    rd_chk(0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/pattern_store.md
PATTERN_STORE -- requirements
Module: pattern_store

Interface
REQ-001 Parameter ROW_W, default 128: bits per grid row.
REQ-002 Parameter ADDR_W, default 10: row address width; depth is 2^ADDR_W rows.
REQ-003 Parameter PAT_ROWS, default 64, power of two: rows per pattern; PSEL_W = ADDR_W - log2(PAT_ROWS).
REQ-004 clka  in  1  single clock; all logic on rising edge.
REQ-005 rsta  in  1  reset, synchronous, active-high.
REQ-006 wea  in  1  host write enable, port A.
REQ-007 addra  in  ADDR_W  host row address, port A.
REQ-008 dina  in  ROW_W  host write data.
REQ-009 douta  out  ROW_W  host read data, registered.
REQ-010 start  in  1  request streaming of one pattern; sampled only in IDLE.
REQ-011 pat_sel  in  PSEL_W  pattern index, captured with start.
REQ-012 busy  out  1  high from accepted start until done pulse inclusive.
REQ-013 done  out  1  one-cycle pulse after last row is accepted.
REQ-014 out_valid  out  1  out_row/out_idx hold a valid row.
REQ-015 out_ready  in  1  downstream accepts row when out_valid and out_ready both high.
REQ-016 out_row  out  ROW_W  streamed row data.
REQ-017 out_idx  out  log2(PAT_ROWS)  row index within pattern, 0..PAT_ROWS-1.

Function
REQ-018 Storage SHALL be one 2^ADDR_W x ROW_W array, port A (host) and port B (engine) independent, both synchronous read.
REQ-019 Port A: wea=1 writes dina to addra at edge; douta SHALL show mem[addra] one cycle after addra presented, read-first (old data on same-address write).
REQ-020 Engine FSM states SHALL be IDLE, FETCH, STREAM, FLUSH.
REQ-021 IDLE -> FETCH on start=1; base address = pat_sel * PAT_ROWS captured; row counter cleared; busy=1 next cycle.
REQ-022 FETCH: port B read of base+0 issued; -> STREAM; first out_valid=1 exactly 2 cycles after start sampled.
REQ-023 STREAM: out_row/out_idx SHALL remain stable while out_valid=1 and out_ready=0; on handshake next row presented in the following cycle (full throughput: one row/cycle when out_ready held high).
REQ-024 Handshake on out_idx = PAT_ROWS-1 -> FLUSH; out_valid=0 next cycle.
REQ-025 FLUSH: done=1 for one cycle, busy=1 in that cycle, -> IDLE; busy=0 following cycle.
REQ-026 start while busy SHALL be ignored; no queuing.
REQ-027 Host write to a row of the pattern being streamed: a row not yet fetched SHALL stream new data; a row already fetched keeps old data.
REQ-028 Same-cycle port A write and port B read of same address: port B returns old data.
REQ-029 Address arithmetic SHALL not wrap across patterns: base+idx stays within the selected pattern for all pat_sel including maximum 2^PSEL_W-1.

Reset
REQ-030 rsta=1 at an edge SHALL force IDLE, busy=0, done=0, out_valid=0, out_idx=0, out_row=0, douta=0.
REQ-031 Reset mid-stream SHALL abort without done pulse; memory contents SHALL be unchanged by reset.
REQ-032 Writes with wea=1 during rsta=1 SHALL be ignored.

Configuration
REQ-033 Macro PATTERN_STORE_MIRROR_EN: when defined, input port mirror (1 bit) is added, captured with start; mirror=1 bit-reverses every streamed out_row (bit i <- bit ROW_W-1-i); douta unaffected.
REQ-034 Without PATTERN_STORE_MIRROR_EN no mirror port exists and out_row equals stored data.

Verification
REQ-035 Write rows 64..127 with dina={row index replicated}; start, pat_sel=1, out_ready=1 -> out_valid at start+2, 64 consecutive rows idx 0..63 matching, done pulse one cycle after idx 63 handshake.
REQ-036 Same stream with out_ready toggling 1/0 every cycle -> no row dropped or duplicated, out_row stable during stalls, 64 handshakes total.
REQ-037 start with pat_sel=15 (max, defaults) -> rows 960..1023 streamed, no access outside range.
REQ-038 rsta asserted after 10 handshakes -> next cycle busy=0, out_valid=0, no done; new start streams from idx 0.
REQ-039 Host writes 0xFFFF...F to row 64 in same cycle engine reads it -> stream shows old value; douta next cycle shows old, following read shows 0xFFFF...F.
REQ-040 With PATTERN_STORE_MIRROR_EN, mirror=1, stored row 0x0000...0001 -> out_row 0x8000...0000.
